// File: rtl/ultrasonic_sensor_bin_to_ascii_converter.sv
// Binary to ASCII decimal converter: repeated restoring divide-by-10, one quotient bit per cycle.
// Digits are collected LSB first and published together with overflow on a one-cycle strobe.
module ultrasonic_sensor_bin_to_ascii_converter #(
    parameter int DATA_WIDTH_P    = 16,
    parameter int NUM_DIGITS_P    = 5,
    parameter int BLANK_LEADING_P = 1
) (
    input  logic                      Clk_i,
    input  logic                      Reset_i,
    input  logic [DATA_WIDTH_P-1:0]   Data_i,
    input  logic                      Data_Valid_i,
    output logic                      Data_Ready_o,
    output logic [8*NUM_DIGITS_P-1:0] Ascii_o,
    output logic                      Ascii_Valid_o,
    output logic                      Overflow_o
);

    localparam int IDX_W = (NUM_DIGITS_P > 1) ? $clog2(NUM_DIGITS_P) : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH_P);
    localparam logic [7:0] FILL_CHAR = (BLANK_LEADING_P != 0) ? 8'h20 : 8'h30;

    function automatic logic [63:0] pow10(input int unsigned k);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < k; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS_P);

    typedef enum logic [1:0] {IDLE, DIVIDE, STORE, DONE} state_t;

    state_t                  state;
    logic [DATA_WIDTH_P-1:0] dividend;
    logic [3:0]              rem;
    logic [CNT_W-1:0]        bit_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [3:0]              digits [NUM_DIGITS_P];
    logic                    ovf_pend;

    logic [4:0]                trial;
    logic                      q_bit;
    logic [3:0]                rem_next;
    logic [8*NUM_DIGITS_P-1:0] ascii_next;
    logic                      shown;

    assign Data_Ready_o = (state == IDLE);

    always_comb begin
        trial    = {rem, dividend[DATA_WIDTH_P-1]};
        q_bit    = (trial >= 5'd10);
        rem_next = q_bit ? 4'(trial - 5'd10) : trial[3:0];
    end

    // Scan from the top slot down; once a non-zero digit (or slot 0) is seen, everything below
    // is printed. An overflowed value has significant digits above the top slot, so nothing blanks.
    always_comb begin
        shown      = ovf_pend || (BLANK_LEADING_P == 0);
        ascii_next = '0;
        for (int unsigned j = 0; j < NUM_DIGITS_P; j++) begin
            if (digits[NUM_DIGITS_P-1-j] != 4'd0 || j == NUM_DIGITS_P - 1) shown = 1'b1;
            ascii_next[8*(NUM_DIGITS_P-1-j) +: 8] = shown ? {4'h3, digits[NUM_DIGITS_P-1-j]} : 8'h20;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state         <= IDLE;
            Ascii_Valid_o <= 1'b0;
            Overflow_o    <= 1'b0;
            Ascii_o       <= {NUM_DIGITS_P{FILL_CHAR}};
            dividend      <= '0;
            rem           <= '0;
            bit_cnt       <= '0;
            digit_idx     <= '0;
            ovf_pend      <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS_P; i++) digits[i] <= '0;
        end else begin
            Ascii_Valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (Data_Valid_i) begin
                        dividend  <= Data_i;
                        rem       <= '0;
                        bit_cnt   <= '0;
                        digit_idx <= '0;
                        ovf_pend  <= (64'(Data_i) >= LIMIT);
                        state     <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    // Quotient bits shift into the vacated LSBs, so after the last bit the
                    // dividend register already holds the quotient.
                    dividend <= {dividend[DATA_WIDTH_P-2:0], q_bit};
                    rem      <= rem_next;
                    if (bit_cnt == CNT_W'(DATA_WIDTH_P - 1)) begin
                        state <= STORE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STORE: begin
                    for (int unsigned i = 0; i < NUM_DIGITS_P; i++) begin
                        if (digit_idx == IDX_W'(i)) digits[i] <= rem;
                    end
                    rem     <= '0;
                    bit_cnt <= '0;
                    if (digit_idx == IDX_W'(NUM_DIGITS_P - 1)) begin
                        state <= DONE;
                    end else begin
                        digit_idx <= digit_idx + IDX_W'(1);
                        state     <= DIVIDE;
                    end
                end
                DONE: begin
                    Ascii_o       <= ascii_next;
                    Overflow_o    <= ovf_pend;
                    Ascii_Valid_o <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_sensor_bin_to_ascii_converter.sv
// Scoreboard bench: four parameter sets run in parallel, each with a driver, an arithmetic
// reference model and a monitor that pops expectations whenever Ascii_Valid_o strobes.
module tb_ultrasonic_sensor_bin_to_ascii_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int W  = (g == 3) ? 10 : 16;
        localparam int N  = (g == 2) ? 4 : (g == 3) ? 3 : 5;
        localparam int B  = (g == 1) ? 0 : 1;
        localparam int L  = N * (W + 1) + 1;
        localparam int NR = (g == 0) ? 400 : (g == 1) ? 150 : (g == 2) ? 250 : 1200;
        localparam int RST_AT = (L / 2 < 40) ? L / 2 : 40;

        logic           rst = 1'b1;
        logic           dv  = 1'b0;
        logic [W-1:0]   din = '0;
        logic           dr, av, ovf;
        logic [8*N-1:0] asc;
        bit             fin = 1'b0;

        logic [79:0] q_asc[$];
        logic        q_ovf[$];
        int unsigned q_acc[$];

        ultrasonic_sensor_bin_to_ascii_converter #(
            .DATA_WIDTH_P(W),
            .NUM_DIGITS_P(N),
            .BLANK_LEADING_P(B)
        ) dut (
            .Clk_i(clk),
            .Reset_i(rst),
            .Data_i(din),
            .Data_Valid_i(dv),
            .Data_Ready_o(dr),
            .Ascii_o(asc),
            .Ascii_Valid_o(av),
            .Overflow_o(ovf)
        );

        function automatic longint unsigned p10(input int k);
            longint unsigned p = 1;
            for (int i = 0; i < k; i++) p = p * 10;
            return p;
        endfunction

        // Decimal rendering from the value itself: blank slot i>0 when the shown value is below 10**i.
        function automatic logic [79:0] ref_ascii(input longint unsigned v);
            logic [79:0]     r = '0;
            longint unsigned m = v % p10(N);
            bit              ov = (v >= p10(N));
            for (int i = 0; i < N; i++) begin
                if (B != 0 && !ov && i > 0 && m < p10(i)) r[8*i +: 8] = 8'h20;
                else r[8*i +: 8] = 8'h30 + 8'((m / p10(i)) % 10);
            end
            return r;
        endfunction

        function automatic logic [79:0] fill_ascii();
            logic [79:0] r = '0;
            for (int i = 0; i < N; i++) r[8*i +: 8] = (B != 0) ? 8'h20 : 8'h30;
            return r;
        endfunction

        function automatic longint unsigned rnd_val();
            longint unsigned mx = (64'd1 << W) - 1;
            longint unsigned v;
            int unsigned     r = $urandom_range(0, 7);
            case (r)
                0: v = 0;
                1: v = mx;
                2: v = p10($urandom_range(1, N)) - $urandom_range(0, 1);
                default: v = longint'($urandom) & mx;
            endcase
            if (v > mx) v = mx;
            return v;
        endfunction

        task automatic wait_ready();
            int unsigned t = 0;
            @(negedge clk);
            while (!dr && t < 4 * L) begin
                @(negedge clk);
                t++;
            end
            if (!dr) chk($sformatf("cfg%0d ready_timeout", g), 80'(dr), 80'(1));
        endtask

        task automatic push_exp(input longint unsigned v);
            q_asc.push_back(ref_ascii(v));
            q_ovf.push_back(v >= p10(N));
            q_acc.push_back(cyc);
        endtask

        task automatic send(input longint unsigned v);
            wait_ready();
            din = W'(v);
            dv  = 1'b1;
            @(posedge clk);
            #1;
            push_exp(v);
            dv = 1'b0;
        endtask

        task automatic drain();
            int unsigned t = 0;
            while (q_asc.size() != 0 && t < L + 10) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("cfg%0d drain", g), 80'(q_asc.size()), 80'(0));
        endtask

        task automatic chk_reset(input string tag);
            chk($sformatf("cfg%0d %s ready", g, tag), 80'(dr), 80'(1));
            chk($sformatf("cfg%0d %s valid", g, tag), 80'(av), 80'(0));
            chk($sformatf("cfg%0d %s overflow", g, tag), 80'(ovf), 80'(0));
            chk($sformatf("cfg%0d %s ascii", g, tag), 80'(asc), fill_ascii());
        endtask

        logic [8*N-1:0] prev_asc;
        logic           prev_rst = 1'b1;
        int unsigned    hold_err = 0;

        always @(negedge clk) begin
            if (av) begin
                if (q_asc.size() == 0) begin
                    chk($sformatf("cfg%0d unexpected_valid", g), 80'(av), 80'(0));
                end else begin
                    logic [79:0] e_asc;
                    logic        e_ovf;
                    int unsigned e_acc;
                    e_asc = q_asc.pop_front();
                    e_ovf = q_ovf.pop_front();
                    e_acc = q_acc.pop_front();
                    chk($sformatf("cfg%0d ascii", g), 80'(asc), e_asc);
                    chk($sformatf("cfg%0d overflow", g), 80'(ovf), 80'(e_ovf));
                    chk($sformatf("cfg%0d latency", g), 80'(cyc - e_acc), 80'(L));
                end
            end else if (!prev_rst && asc !== prev_asc) begin
                hold_err++;
            end
            prev_asc = asc;
            prev_rst = rst;
        end

        initial begin
            longint unsigned dir[$];
            int unsigned     acc0, acc1, n;

            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk_reset("reset");

            case (g)
                0: dir = '{0, 1234, 65535, 10, 100, 9};
                1: dir = '{1234, 0, 65535, 10};
                2: dir = '{12345, 999, 9999, 10000, 65535, 0};
                default: dir = '{999, 1000, 1023, 0, 7};
            endcase
            foreach (dir[k]) send(dir[k]);

            // Valid held high with changing data while busy: only the first value counts.
            wait_ready();
            din = W'(rnd_val());
            dv  = 1'b1;
            @(posedge clk);
            #1;
            acc0 = cyc;
            push_exp(longint'(din));
            n = 0;
            forever begin
                @(negedge clk);
                if (dr || n > 4 * L) break;
                din = W'(rnd_val());
                n++;
            end
            chk($sformatf("cfg%0d busy_len", g), 80'(n), 80'(L));
            din = W'(rnd_val());
            @(posedge clk);
            #1;
            acc1 = cyc;
            chk($sformatf("cfg%0d next_accept", g), 80'(acc1 - acc0), 80'(L + 1));
            push_exp(longint'(din));
            dv = 1'b0;

            // Reset during a conversion aborts it silently.
            send(longint'((64'd1 << W) - 1));
            repeat (RST_AT - 1) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            q_asc.delete();
            q_ovf.delete();
            q_acc.delete();
            @(negedge clk);
            chk_reset("abort");
            repeat (L + 5) @(negedge clk);
            send(42);

            for (int i = 0; i < NR; i++) send(rnd_val());
            drain();
            chk($sformatf("cfg%0d hold_between_strobes", g), 80'(hold_err), 80'(0));
            fin = 1'b1;
        end
    end

    initial begin
        int unsigned t = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin) && t < 90000) begin
            @(posedge clk);
            t++;
        end
        if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin)) begin
            tests++;
            fails++;
            $display("FAIL watchdog: finished %b%b%b%b required 1111",
                     cfg[3].fin, cfg[2].fin, cfg[1].fin, cfg[0].fin);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
